// File: rtl/bank_sched.sv
// Row-bank scheduler: sweeps enabled banks in cyclic order for num_rows rows.
// Optional BANK_SCHED_MASK_EN adds a per-schedule bank_mask input.
module bank_sched #(
  parameter int POY   = 3,
  parameter int ROW_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [ROW_W-1:0] num_rows,
  input  logic [POY-1:0]   bank_rdy,
`ifdef BANK_SCHED_MASK_EN
  input  logic [POY-1:0]   bank_mask,
`endif
  input  logic             out_ready,
  output logic [7:0]       bank,
  output logic             sel_valid,
  output logic [ROW_W-1:0] row_cnt,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t           state_q, state_d;
  logic [7:0]       bank_q, bank_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic [ROW_W-1:0] rows_q, rows_d;
  logic [POY-1:0]   en_q, en_d;
  logic [POY-1:0]   en_start;
  logic [7:0]       first, lowest, above, nxt;
  logic             found, wrap, rdy_cur, xfer;

`ifdef BANK_SCHED_MASK_EN
  assign en_start = bank_mask;
`else
  assign en_start = '1;
`endif

  always_comb begin
    first   = '0;
    lowest  = '0;
    above   = '0;
    found   = 1'b0;
    rdy_cur = 1'b0;
    for (int i = POY - 1; i >= 0; i--) begin
      if (en_start[i]) first = 8'(i);
      if (en_q[i]) lowest = 8'(i);
      if (en_q[i] && 8'(i) > bank_q) begin
        above = 8'(i);
        found = 1'b1;
      end
      if (bank_q == 8'(i)) rdy_cur = bank_rdy[i];
    end
    nxt  = found ? above : lowest;
    wrap = !found;
  end

  assign busy      = (state_q == RUN);
  assign done      = (state_q == FIN);
  assign sel_valid = busy && rdy_cur;
  assign xfer      = sel_valid && out_ready;
  assign bank      = bank_q;
  assign row_cnt   = row_q;

  always_comb begin
    state_d = state_q;
    bank_d  = bank_q;
    row_d   = row_q;
    rows_d  = rows_q;
    en_d    = en_q;
    unique case (state_q)
      IDLE: begin
        if (start && !abort) begin
          if (num_rows == '0 || en_start == '0) begin
            state_d = FIN;
          end else begin
            state_d = RUN;
            rows_d  = num_rows;
            en_d    = en_start;
            bank_d  = first;
            row_d   = '0;
          end
        end
      end
      RUN: begin
        if (abort) begin
          state_d = IDLE;
          bank_d  = '0;
          row_d   = '0;
        end else if (xfer) begin
          // the final transfer freezes bank/row_cnt where they are
          if (wrap && row_q == rows_q - ROW_W'(1)) begin
            state_d = FIN;
          end else begin
            bank_d = nxt;
            if (wrap) row_d = row_q + ROW_W'(1);
          end
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      bank_q  <= '0;
      row_q   <= '0;
      rows_q  <= '0;
      en_q    <= '0;
    end else begin
      state_q <= state_d;
      bank_q  <= bank_d;
      row_q   <= row_d;
      rows_q  <= rows_d;
      en_q    <= en_d;
    end
  end

endmodule
